branch_hazard_ctrl: RTL and testbench



---
 rtl/cpu_ctrl_pkg.sv | 9 +
 rtl/sat_counter.sv | 24 ++
 rtl/branch_hazard_ctrl.sv | 105 ++++++++++
 tb/tb_branch_hazard_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared constants and types for the branch/hazard pipeline control slice.
package cpu_ctrl_pkg;
   localparam logic [4:0] OP_BE         = 5'b00011;
   localparam logic [1:0] PC_SEL_PLUS1  = 2'b00;
   localparam logic [1:0] PC_SEL_BRANCH = 2'b01;
   localparam int         FCNT_W        = 3;

   typedef enum logic {RUN, FLUSH} state_t;
endpackage

// File: rtl/sat_counter.sv
// Event counter that holds at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   logic [CNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}}))
         count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;
endmodule

// File: rtl/branch_hazard_ctrl.sv
// PC / pipeline-register sequencing around taken branches and load-use stalls,
// with saturating event counters.
module branch_hazard_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 2,
   parameter int REG_W        = 4,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_valid,
   input  logic [4:0]       ex_opcode,
   input  logic [1:0]       ex_select_pc,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             id_valid,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   output logic [1:0]       pc_sel,
   output logic             pc_write_en,
   output logic             ifid_write_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             busy,
   output logic [CNT_W-1:0] taken_cnt,
   output logic [CNT_W-1:0] not_taken_cnt,
   output logic [CNT_W-1:0] stall_cnt
);
   state_t              state_q, state_d;
   logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
   logic                taken, not_taken, load_use;
   logic                inc_taken, inc_not_taken, inc_stall;

   assign taken     = ex_valid && (ex_opcode == OP_BE) && (ex_select_pc == PC_SEL_BRANCH);
   assign not_taken = ex_valid && (ex_opcode == OP_BE) && (ex_select_pc == PC_SEL_PLUS1);
   assign load_use  = ex_valid && ex_is_load && (ex_rd != '0) && id_valid &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   // Outputs are forced to their idle values while rst is high so an
   // asynchronous reset takes effect on the decision lines immediately.
   always_comb begin
      state_d       = state_q;
      fcnt_d        = fcnt_q;
      pc_sel        = PC_SEL_PLUS1;
      pc_write_en   = 1'b1;
      ifid_write_en = 1'b1;
      ifid_flush    = 1'b0;
      idex_flush    = 1'b0;
      busy          = 1'b0;
      inc_taken     = 1'b0;
      inc_not_taken = 1'b0;
      inc_stall     = 1'b0;
      if (!rst) begin
         case (state_q)
            RUN: begin
               inc_not_taken = not_taken;
               if (taken) begin
                  pc_sel     = PC_SEL_BRANCH;
                  ifid_flush = 1'b1;
                  idex_flush = 1'b1;
                  inc_taken  = 1'b1;
                  if (FLUSH_CYCLES > 1) begin
                     fcnt_d  = FCNT_W'(FLUSH_CYCLES - 1);
                     state_d = FLUSH;
                  end
               end else if (load_use) begin
                  pc_write_en   = 1'b0;
                  ifid_write_en = 1'b0;
                  idex_flush    = 1'b1;
                  inc_stall     = 1'b1;
               end
            end
            FLUSH: begin
               ifid_flush = 1'b1;
               idex_flush = 1'b1;
               busy       = 1'b1;
               fcnt_d     = fcnt_q - 1'b1;
               if (fcnt_q <= 1) state_d = RUN;
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
      .clk(clk), .rst(rst), .inc(inc_taken), .count(taken_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_not_taken_cnt (
      .clk(clk), .rst(rst), .inc(inc_not_taken), .count(not_taken_cnt)
   );
   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk(clk), .rst(rst), .inc(inc_stall), .count(stall_cnt)
   );
endmodule

// File: tb/tb_branch_hazard_ctrl.sv
// Directed and random checks of branch_hazard_ctrl against a cycle-level
// behavioural model (FLUSH_CYCLES=2, CNT_W=4).
module tb_branch_hazard_ctrl;
   localparam int FC    = 2;
   localparam int REG_W = 4;
   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             ex_valid;
   logic [4:0]       ex_opcode;
   logic [1:0]       ex_select_pc;
   logic             ex_is_load;
   logic [REG_W-1:0] ex_rd;
   logic             id_valid;
   logic [REG_W-1:0] id_rs1, id_rs2;
   logic [1:0]       pc_sel;
   logic             pc_write_en, ifid_write_en, ifid_flush, idex_flush, busy;
   logic [CNT_W-1:0] taken_cnt, not_taken_cnt, stall_cnt;

   int n_assert = 0;
   int n_fail   = 0;

   // Model state: remaining flush cycles after the current one, event tallies.
   int m_flush_left;
   int m_tk, m_nt, m_st;
   bit d_taken, d_nt, d_stall;
   logic [1:0] e_pc_sel;
   logic e_pcwe, e_ifwe, e_iff, e_idf, e_busy;

   branch_hazard_ctrl #(.FLUSH_CYCLES(FC), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_select_pc(ex_select_pc), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
      .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .pc_sel(pc_sel), .pc_write_en(pc_write_en), .ifid_write_en(ifid_write_en),
      .ifid_flush(ifid_flush), .idex_flush(idex_flush), .busy(busy),
      .taken_cnt(taken_cnt), .not_taken_cnt(not_taken_cnt), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_in(input bit v, input logic [4:0] op, input logic [1:0] sel,
                         input bit ld, input logic [3:0] rd, input bit idv,
                         input logic [3:0] rs1, input logic [3:0] rs2);
      ex_valid = v; ex_opcode = op; ex_select_pc = sel; ex_is_load = ld;
      ex_rd = rd; id_valid = idv; id_rs1 = rs1; id_rs2 = rs2;
   endtask

   function automatic int sat_inc(input int x);
      return (x + 1 > CMAX) ? CMAX : x + 1;
   endfunction

   task automatic model_reset();
      m_flush_left = 0; m_tk = 0; m_nt = 0; m_st = 0;
   endtask

   task automatic model_outs();
      bit is_be, tk, nt, lu;
      is_be = ex_valid && (ex_opcode == 5'd3);
      tk = is_be && (ex_select_pc == 2'd1);
      nt = is_be && (ex_select_pc == 2'd0);
      lu = ex_valid && ex_is_load && (ex_rd != 0) && id_valid &&
           ((ex_rd == id_rs1) || (ex_rd == id_rs2));
      e_pc_sel = 2'd0; e_pcwe = 1; e_ifwe = 1; e_iff = 0; e_idf = 0; e_busy = 0;
      d_taken = 0; d_nt = 0; d_stall = 0;
      if (m_flush_left > 0) begin
         e_iff = 1; e_idf = 1; e_busy = 1;
      end else begin
         d_nt = nt;
         if (tk) begin
            e_pc_sel = 2'd1; e_iff = 1; e_idf = 1; d_taken = 1;
         end else if (lu) begin
            e_pcwe = 0; e_ifwe = 0; e_idf = 1; d_stall = 1;
         end
      end
   endtask

   task automatic model_step();
      if (m_flush_left > 0) m_flush_left--;
      else if (d_taken) m_flush_left = FC - 1;
      if (d_taken) m_tk = sat_inc(m_tk);
      if (d_nt)    m_nt = sat_inc(m_nt);
      if (d_stall) m_st = sat_inc(m_st);
   endtask

   task automatic chk_outs(input string tag);
      chk({tag, ".pc_sel"}, 16'(pc_sel), 16'(e_pc_sel));
      chk({tag, ".pc_write_en"}, 16'(pc_write_en), 16'(e_pcwe));
      chk({tag, ".ifid_write_en"}, 16'(ifid_write_en), 16'(e_ifwe));
      chk({tag, ".ifid_flush"}, 16'(ifid_flush), 16'(e_iff));
      chk({tag, ".idex_flush"}, 16'(idex_flush), 16'(e_idf));
      chk({tag, ".busy"}, 16'(busy), 16'(e_busy));
   endtask

   task automatic chk_cnts(input string tag);
      chk({tag, ".taken_cnt"}, 16'(taken_cnt), 16'(m_tk));
      chk({tag, ".not_taken_cnt"}, 16'(not_taken_cnt), 16'(m_nt));
      chk({tag, ".stall_cnt"}, 16'(stall_cnt), 16'(m_st));
   endtask

   // Called just after a falling edge with inputs already applied.
   task automatic do_cycle(input string tag);
      #2;
      model_outs();
      chk_outs(tag);
      @(posedge clk);
      model_step();
      #1;
      chk_cnts(tag);
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1;
      model_reset();
      // Reset must mask outputs even with a taken branch presented.
      set_in(1, 5'd3, 2'd1, 1, 4'd3, 1, 4'd3, 4'd3);
      #2;
      chk("rst.pc_sel", 16'(pc_sel), 16'd0);
      chk("rst.pc_write_en", 16'(pc_write_en), 16'd1);
      chk("rst.ifid_write_en", 16'(ifid_write_en), 16'd1);
      chk("rst.ifid_flush", 16'(ifid_flush), 16'd0);
      chk("rst.idex_flush", 16'(idex_flush), 16'd0);
      chk("rst.busy", 16'(busy), 16'd0);
      chk_cnts("rst");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      set_in(0, 5'd0, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);

      do_cycle("idle0");
      do_cycle("idle1");

      // Taken branch then its flush window.
      set_in(1, 5'd3, 2'd1, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("br.T");
      set_in(0, 5'd0, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("br.T1");
      do_cycle("br.T2");

      // Load-use on rs2, then the same with rd=0.
      set_in(1, 5'd0, 2'd0, 1, 4'd3, 1, 4'd0, 4'd3);
      do_cycle("lu.hit");
      set_in(1, 5'd0, 2'd0, 1, 4'd0, 1, 4'd0, 4'd0);
      do_cycle("lu.rd0");

      // Branch and load-use together: branch wins.
      set_in(1, 5'd3, 2'd1, 1, 4'd5, 1, 4'd5, 4'd1);
      do_cycle("brlu.T");
      // Taken branch while flushing is ignored.
      set_in(1, 5'd3, 2'd1, 1, 4'd5, 1, 4'd5, 4'd1);
      do_cycle("brlu.T1");
      // Back-to-back: first RUN cycle after flush accepts a branch.
      do_cycle("b2b.T");
      set_in(0, 5'd0, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("b2b.T1");

      // Not-taken saturation, then select=10 must not count.
      set_in(1, 5'd3, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);
      for (int i = 0; i < 20; i++) do_cycle("nt.sat");
      chk("nt.sat.final", 16'(not_taken_cnt), 16'(CMAX));
      set_in(1, 5'd3, 2'd2, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("sel10");

      // Random traffic.
      for (int i = 0; i < 300; i++) begin
         set_in($urandom_range(0, 3) != 0,
                ($urandom_range(0, 1) != 0) ? 5'd3 : 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
                4'($urandom_range(0, 3)), $urandom_range(0, 3) != 0,
                4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)));
         do_cycle("rand");
      end

      // Asynchronous reset in the middle of a flush window.
      set_in(0, 5'd0, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("arst.pre");
      set_in(1, 5'd3, 2'd1, 0, 4'd0, 0, 4'd0, 4'd0);
      do_cycle("arst.T");
      set_in(0, 5'd0, 2'd0, 0, 4'd0, 0, 4'd0, 4'd0);
      #2;
      chk("arst.busy_before", 16'(busy), 16'd1);
      rst = 1'b1;
      #1;
      model_reset();
      chk("arst.busy", 16'(busy), 16'd0);
      chk("arst.ifid_flush", 16'(ifid_flush), 16'd0);
      chk("arst.idex_flush", 16'(idex_flush), 16'd0);
      chk_cnts("arst");
      @(negedge clk);
      rst = 1'b0;
      do_cycle("arst.after");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
